// File: rtl/data_memory_responder.sv
// Word-addressed data memory slave with a valid/ready request channel and a valid/ready response channel.
// Latency: accept at edge N, response registered at edge N+LATENCY and first sampled high at edge N+1+LATENCY.
// Backpressure: one request in flight; req_ready stays low until the response retires under resp_ready.
module data_memory_responder #(
    parameter int          DEPTH_WORDS  = 64,
    parameter int          LATENCY      = 2,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_read_data,
    output logic        resp_error
);

    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD  = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  wait_cnt, wait_cnt_nxt;
    logic        lat_write, lat_write_nxt;
    logic [31:0] lat_address, lat_address_nxt;
    logic [31:0] lat_write_data, lat_write_data_nxt;
    logic        req_ready_nxt;
    logic        resp_valid_nxt;
    logic        resp_error_nxt;
    logic [31:0] resp_read_data_nxt;

    logic [31:0] mem [DEPTH_WORDS];

    logic             acc_write;
    logic [31:0]      acc_address;
    logic [31:0]      acc_write_data;
    logic [32:0]      acc_diff;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic             do_access;
    logic             mem_we;

    // Access operands: with zero latency the access happens on the accept edge, so use the live request.
    always_comb begin
        acc_write      = lat_write;
        acc_address    = lat_address;
        acc_write_data = lat_write_data;
        if (state == IDLE) begin
            acc_write      = req_write;
            acc_address    = req_address;
            acc_write_data = req_write_data;
        end
        // 33-bit subtract: the top bit is the borrow, i.e. address below the base.
        acc_diff = {1'b0, acc_address} - {1'b0, BASE_ADDRESS};
        acc_err  = (acc_address[1:0] != 2'b00) || acc_diff[32] ||
                   (acc_diff[31:0] >= SPAN_BYTES);
        acc_idx  = IDX_W'(acc_diff[31:0] >> 2);
    end

    // Next-state, latched request and registered output values.
    always_comb begin
        state_nxt          = state;
        wait_cnt_nxt       = wait_cnt;
        lat_write_nxt      = lat_write;
        lat_address_nxt    = lat_address;
        lat_write_data_nxt = lat_write_data;
        req_ready_nxt      = req_ready;
        resp_valid_nxt     = resp_valid;
        resp_error_nxt     = resp_error;
        resp_read_data_nxt = resp_read_data;
        do_access          = 1'b0;

        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (req_valid && req_ready) begin
                    lat_write_nxt      = req_write;
                    lat_address_nxt    = req_address;
                    lat_write_data_nxt = req_write_data;
                    req_ready_nxt      = 1'b0;
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                        do_access = 1'b1;
                    end else begin
                        wait_cnt_nxt = WAIT_LOAD;
                        state_nxt    = WAIT;
                    end
                end
            end
            WAIT: begin
                req_ready_nxt = 1'b0;
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                    do_access = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_nxt     = 1'b0;
                    resp_error_nxt     = 1'b0;
                    resp_read_data_nxt = 32'd0;
                    req_ready_nxt      = 1'b1;
                    state_nxt          = IDLE;
                end
            end
            default: begin
                state_nxt     = IDLE;
                req_ready_nxt = 1'b0;
            end
        endcase

        if (do_access) begin
            resp_valid_nxt     = 1'b1;
            resp_error_nxt     = acc_err;
            resp_read_data_nxt = (acc_err || acc_write) ? 32'd0 : mem[acc_idx];
        end
    end

    assign mem_we = do_access && acc_write && !acc_err;

    // State and output registers; clear aborts any transaction in flight.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state          <= IDLE;
            wait_cnt       <= 4'd0;
            lat_write      <= 1'b0;
            lat_address    <= 32'd0;
            lat_write_data <= 32'd0;
            req_ready      <= 1'b0;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_read_data <= 32'd0;
        end else begin
            state          <= state_nxt;
            wait_cnt       <= wait_cnt_nxt;
            lat_write      <= lat_write_nxt;
            lat_address    <= lat_address_nxt;
            lat_write_data <= lat_write_data_nxt;
            req_ready      <= req_ready_nxt;
            resp_valid     <= resp_valid_nxt;
            resp_error     <= resp_error_nxt;
            resp_read_data <= resp_read_data_nxt;
        end
    end

    // Storage: zeroed by clear, written only by a valid in-range store entering RESP.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (mem_we) begin
            mem[acc_idx] <= acc_write_data;
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: three responders (LATENCY 0 with base 0x1000/16 words, LATENCY 2, LATENCY 15).
// Each transaction checks handshake timing, response data/error, hold under backpressure and retirement.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_data_memory_responder;

    logic        clock = 1'b0;
    logic        clear;
    logic        req_valid      [3];
    logic        req_ready      [3];
    logic        req_write      [3];
    logic [31:0] req_address    [3];
    logic [31:0] req_write_data [3];
    logic        resp_valid     [3];
    logic        resp_ready     [3];
    logic [31:0] resp_read_data [3];
    logic        resp_error     [3];

    int checks = 0;
    int errors = 0;

    localparam int LAT [3] = '{0, 2, 15};

    always #5 clock = ~clock;

    data_memory_responder #(.DEPTH_WORDS(16), .LATENCY(0), .BASE_ADDRESS(32'h0000_1000)) u_lat0 (
        .clock(clock), .clear(clear),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_address(req_address[0]), .req_write_data(req_write_data[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_read_data(resp_read_data[0]), .resp_error(resp_error[0])
    );

    data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(2), .BASE_ADDRESS(32'h0000_0000)) u_lat2 (
        .clock(clock), .clear(clear),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_address(req_address[1]), .req_write_data(req_write_data[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_read_data(resp_read_data[1]), .resp_error(resp_error[1])
    );

    data_memory_responder #(.DEPTH_WORDS(64), .LATENCY(15), .BASE_ADDRESS(32'h0000_0000)) u_lat15 (
        .clock(clock), .clear(clear),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_address(req_address[2]), .req_write_data(req_write_data[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_read_data(resp_read_data[2]), .resp_error(resp_error[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One request on responder i; expects sampled-valid at 1+LATENCY edges after accept.
    // hold > 0 keeps resp_ready low for that many cycles; toggle wiggles req_valid during WAIT.
    task automatic txn(input int i, input string tag, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err,
                       input int hold, input bit toggle);
        int c;
        c = 0;
        while (!req_ready[i] && c < 50) begin
            @(negedge clock);
            c++;
        end
        check($sformatf("%s_rdy", tag), req_ready[i], 1);
        req_valid[i]      = 1'b1;
        req_write[i]      = wr;
        req_address[i]    = addr;
        req_write_data[i] = wdata;
        resp_ready[i]     = (hold == 0);
        @(negedge clock);
        req_valid[i] = 1'b0;
        c = 1;
        while (!resp_valid[i] && c < 40) begin
            if (toggle) begin
                req_valid[i]      = ~req_valid[i];
                req_write[i]      = 1'b1;
                req_address[i]    = 32'h0000_0010;
                req_write_data[i] = 32'hBAD0_BAD0;
            end
            @(negedge clock);
            c++;
        end
        req_valid[i] = 1'b0;
        check($sformatf("%s_lat", tag), c, LAT[i] + 1);
        check($sformatf("%s_data", tag), resp_read_data[i], exp_data);
        check($sformatf("%s_err", tag), resp_error[i], exp_err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check($sformatf("%s_hold_vld", tag), resp_valid[i], 1);
            check($sformatf("%s_hold_data", tag), resp_read_data[i], exp_data);
            check($sformatf("%s_hold_err", tag), resp_error[i], exp_err);
            check($sformatf("%s_hold_rdy", tag), req_ready[i], 0);
        end
        resp_ready[i] = 1'b1;
        @(negedge clock);
        check($sformatf("%s_ret_vld", tag), resp_valid[i], 0);
        check($sformatf("%s_ret_rdy", tag), req_ready[i], 1);
        check($sformatf("%s_ret_data", tag), resp_read_data[i], 0);
        check($sformatf("%s_ret_err", tag), resp_error[i], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            req_valid[i]      = 1'b0;
            req_write[i]      = 1'b0;
            req_address[i]    = 32'd0;
            req_write_data[i] = 32'd0;
            resp_ready[i]     = 1'b1;
        end
        clear = 1'b1;
        #2 clear = 1'b0;

        // Reset and idle behaviour.
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst%0d_rdy", i), req_ready[i], 0);
            check($sformatf("rst%0d_vld", i), resp_valid[i], 0);
            check($sformatf("rst%0d_data", i), resp_read_data[i], 0);
            check($sformatf("rst%0d_err", i), resp_error[i], 0);
        end
        clear = 1'b1;
        #1 check("rel_rdy_before_edge", req_ready[1], 0);
        @(negedge clock);
        for (int i = 0; i < 3; i++) check($sformatf("rel%0d_rdy", i), req_ready[i], 1);
        repeat (3) @(negedge clock);
        for (int i = 0; i < 3; i++) check($sformatf("idle%0d_vld", i), resp_valid[i], 0);

        // LATENCY=2 responder: store/load, backpressure, errors, boundaries, ignored WAIT traffic.
        txn(1, "st10",     1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0, 1'b0);
        txn(1, "ld10",     1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        txn(1, "ld10_bp",  1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 5, 1'b0);
        txn(1, "st12_mis", 1'b1, 32'h0000_0012, 32'h1234_5678, 32'h0000_0000, 1'b1, 0, 1'b0);
        txn(1, "ld10_aft", 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        txn(1, "ld100_oor",1'b0, 32'h0000_0100, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0);
        txn(1, "stFC",     1'b1, 32'h0000_00FC, 32'hA5A5_0001, 32'h0000_0000, 1'b0, 0, 1'b0);
        txn(1, "ldFC",     1'b0, 32'h0000_00FC, 32'h0,         32'hA5A5_0001, 1'b0, 0, 1'b0);
        txn(1, "st0_tog",  1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0, 0, 1'b1);
        txn(1, "ld10_tog", 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        txn(1, "ld0",      1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0, 0, 1'b0);

        // LATENCY=15 responder: long wait with req_valid toggling, separate storage.
        txn(2, "l15_st40", 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 0, 1'b1);
        txn(2, "l15_ld40", 1'b0, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 1'b0, 0, 1'b0);
        txn(2, "l15_ld10", 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 1'b0, 0, 1'b0);

        // LATENCY=0 responder at base 0x1000 with 16 words.
        txn(0, "l0_st1000", 1'b1, 32'h0000_1000, 32'h0102_0304, 32'h0000_0000, 1'b0, 0, 1'b0);
        txn(0, "l0_ld1000", 1'b0, 32'h0000_1000, 32'h0,         32'h0102_0304, 1'b0, 0, 1'b0);
        txn(0, "l0_ldFFC",  1'b0, 32'h0000_0FFC, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0);
        txn(0, "l0_st103C", 1'b1, 32'h0000_103C, 32'h0000_0077, 32'h0000_0000, 1'b0, 0, 1'b0);
        txn(0, "l0_ld103C", 1'b0, 32'h0000_103C, 32'h0,         32'h0000_0077, 1'b0, 0, 1'b0);
        txn(0, "l0_ld1040", 1'b0, 32'h0000_1040, 32'h0,         32'h0000_0000, 1'b1, 0, 1'b0);
        txn(0, "l0_st1001", 1'b1, 32'h0000_1001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2, 1'b0);
        txn(0, "l0_ld1000b",1'b0, 32'h0000_1000, 32'h0,         32'h0102_0304, 1'b0, 0, 1'b0);

        // Clear during WAIT of a pending store on the LATENCY=15 responder.
        req_valid[2]      = 1'b1;
        req_write[2]      = 1'b1;
        req_address[2]    = 32'h0000_0040;
        req_write_data[2] = 32'h5555_5555;
        @(negedge clock);
        req_valid[2] = 1'b0;
        repeat (3) @(negedge clock);
        check("mid_wait_vld", resp_valid[2], 0);
        check("mid_wait_rdy", req_ready[2], 0);
        clear = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("mid%0d_rdy", i), req_ready[i], 0);
            check($sformatf("mid%0d_vld", i), resp_valid[i], 0);
        end
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        txn(2, "post_l15_ld40",  1'b0, 32'h0000_0040, 32'h0, 32'h0000_0000, 1'b0, 0, 1'b0);
        txn(1, "post_l2_ld10",   1'b0, 32'h0000_0010, 32'h0, 32'h0000_0000, 1'b0, 0, 1'b0);
        txn(0, "post_l0_ld1000", 1'b0, 32'h0000_1000, 32'h0, 32'h0000_0000, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
